// File: rtl/word_unpacker_pkg.sv
// rtl/word_unpacker_pkg.sv - shared widths and lane mapping for the 128<->32 packer/unpacker pair
package word_unpacker_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int LANES      = 4;

    typedef enum logic {
        ST_COLLECT  = 1'b0,
        ST_COMPLETE = 1'b1
    } state_e;

    function automatic logic [1:0] lane_idx(input logic [3:0] addr);
        return addr[3:2];
    endfunction

    function automatic int lane_lsb(input logic [1:0] lane, input int data_w);
        return int'(lane) * data_w;
    endfunction

endpackage

// File: rtl/unpack_out_reg.sv
// rtl/unpack_out_reg.sv - wide valid/ready holding register (load, hold, drain)
module unpack_out_reg #(
    parameter int W = 128
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         free_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/word_unpacker.sv
// rtl/word_unpacker.sv - assembles four address-tagged 32-bit words into one 128-bit line
module word_unpacker
    import word_unpacker_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int ADDR_W = ADDR_W_DEF,
    localparam int OUT_W  = LANES * DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [ADDR_W-1:0] address_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic              err_misalign_o,
    output logic              err_dup_o
);

    logic [OUT_W-1:0] stage_q, stage_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic             err_dup_q, err_dup_d;
    logic             err_mis_q, err_mis_d;

    state_e     state;
    logic       out_free;
    logic       xfer;
    logic       accept;
    logic       aligned;
    logic [1:0] lane;

    // State is implied by the mask: all lanes present means the line is complete.
    assign state      = (mask_q == '1) ? ST_COMPLETE : ST_COLLECT;
    assign xfer       = (state == ST_COMPLETE) && out_free;
    assign in_ready_o = (state != ST_COMPLETE) || xfer;
    assign accept     = in_valid_i && in_ready_o;
    assign aligned    = (address_i[1:0] == 2'b00);
    assign lane       = lane_idx(address_i[3:0]);

    always_comb begin
        stage_d   = stage_q;
        mask_d    = xfer ? '0 : mask_q;
        err_dup_d = 1'b0;
        err_mis_d = accept && !aligned;
        if (clr_i) begin
            mask_d = '0;
        end else if (accept && aligned) begin
            stage_d[lane_lsb(lane, DATA_W) +: DATA_W] = in_data_i;
            mask_d[lane] = 1'b1;
            // A word landing alongside the hand-off starts a fresh line, so it is never a duplicate.
            err_dup_d = mask_q[lane] && !xfer;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q   <= '0;
            mask_q    <= '0;
            err_dup_q <= 1'b0;
            err_mis_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            mask_q    <= mask_d;
            err_dup_q <= err_dup_d;
            err_mis_q <= err_mis_d;
        end
    end

    assign err_dup_o      = err_dup_q;
    assign err_misalign_o = err_mis_q;

    unpack_out_reg #(
        .W(OUT_W)
    ) u_out_reg (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (xfer),
        .data_i (stage_q),
        .ready_i(out_ready_i),
        .valid_o(out_valid_o),
        .data_o (out_data_o),
        .free_o (out_free)
    );

endmodule
